if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_pkg.sv | 24 ++
 rtl/if_icache.sv | 44 ++++
 rtl/if_fetch.sv | 131 +++++++++++++
 tb/tb_if_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage and its optional cache.
package if_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  localparam logic [2:0] IFCU_VALID = 3'd0;
  localparam logic [2:0] IFCU_BUSY  = 3'd1;
  localparam logic [2:0] IFCU_FLUSH = 3'd2;
  localparam logic [2:0] IFCU_STALL = 3'd4;

  localparam int IC_ENTRIES = 16;
  localparam int IC_IDX_W   = 4;
  localparam int IC_TAG_W   = 26;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_icache.sv
// 16-entry direct-mapped instruction cache, word-addressed: combinational lookup,
// write takes effect on the next clock edge; no backpressure, valid bits cleared by reset.
module if_icache
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] rd_waddr,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [29:0] wr_waddr,
  input  logic [31:0] wr_data
);

  logic [IC_ENTRIES-1:0] valid_q, valid_d;
  logic [IC_TAG_W-1:0]   tag_q  [IC_ENTRIES];
  logic [31:0]           data_q [IC_ENTRIES];
  logic [IC_IDX_W-1:0]   rd_idx, wr_idx;

  assign rd_idx  = rd_waddr[IC_IDX_W-1:0];
  assign wr_idx  = wr_waddr[IC_IDX_W-1:0];
  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_waddr[29:IC_IDX_W]);
  assign rd_data = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Tag and data need no reset: a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_waddr[29:IC_IDX_W];
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Byte-serial instruction fetch: 8-cycle best-case miss latency, 1 cycle on a hit with IF_ICACHE_EN;
// stall holds the presented word, br_taken redirects and overrides stall.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_is,
  output logic [2:0]  if_cu
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  is_q, is_d;
  logic [1:0]   idx_q, idx_d;
  logic         hit;
  logic [31:0]  hit_data;

`ifdef IF_ICACHE_EN
  logic ic_hit;
  logic fill;

  // Only completed fetches fill; a redirect in the last WAIT cycle discards the word.
  assign fill = (state_q == ST_WAIT) && mem_rvalid && (idx_q == 2'd3) && !br_taken;
  assign hit  = ic_hit && (state_q == ST_REQ) && (idx_q == 2'd0);

  if_icache u_icache (
    .clk      (clk),
    .rst      (rst),
    .rd_waddr (pc_q[31:2]),
    .rd_hit   (ic_hit),
    .rd_data  (hit_data),
    .wr_en    (fill),
    .wr_waddr (pc_q[31:2]),
    .wr_data  (is_d)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign mem_req  = rst && (state_q == ST_REQ) && !hit;
  assign mem_addr = pc_q + {30'd0, idx_q};
  assign if_pc    = pc_q;
  assign if_is    = is_q;

  always_comb begin
    if_cu = IFCU_BUSY;
    if (rst) begin
      if (br_taken)                if_cu = IFCU_FLUSH;
      else if (state_q == ST_DONE) if_cu = stall ? IFCU_STALL : IFCU_VALID;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    is_d    = is_q;
    if (br_taken) begin
      pc_d  = align_word(br_target);
      idx_d = 2'd0;
      // A granted byte still in flight must be swallowed before refetching.
      if ((state_q == ST_WAIT  && !mem_rvalid) ||
          (state_q == ST_DRAIN && !mem_rvalid) ||
          (mem_req && mem_gnt))
        state_d = ST_DRAIN;
      else
        state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (hit) begin
            is_d    = hit_data;
            state_d = ST_DONE;
          end else if (mem_gnt) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            is_d[{idx_q, 3'b000} +: 8] = mem_rdata;
            if (idx_q == 2'd3) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = ST_REQ;
            end
          end
        end
        ST_DRAIN: begin
          if (mem_rvalid) state_d = ST_REQ;
        end
        ST_DONE: begin
          if (!stall) begin
            pc_d    = pc_q + 32'd4;
            idx_d   = 2'd0;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      idx_q   <= 2'd0;
      is_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      is_q    <= is_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by randomized traffic against a
// transaction-level model (fetch pc, bytes collected, byte to discard, word cache).
module tb_if_fetch;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, mem_req, mem_gnt, mem_rvalid;
  logic [31:0] br_target, mem_addr, if_pc, if_is;
  logic [7:0]  mem_rdata;
  logic [2:0]  if_cu;

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .if_pc      (if_pc),
    .if_is      (if_is),
    .if_cu      (if_cu)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [1024];

  logic [31:0] mpc;
  int          nb;
  bit          disc, pend, hit_done;
  int          pend_dly;
  logic [31:0] pend_addr;
  bit          rand_gnt;
  int          rv_dly_cfg;
  bit          s_rst, s_stall, s_br;
  logic [31:0] s_tgt;
`ifdef IF_ICACHE_EN
  bit          cvalid [16];
  logic [31:0] cpc    [16];
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] b;
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = a + k;
      w[8*k +: 8] = mem[b[9:0]];
    end
    return w;
  endfunction

  function automatic bit model_hit();
`ifdef IF_ICACHE_EN
    return cvalid[mpc[5:2]] && (cpc[mpc[5:2]] == mpc);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mpc = RST_PC; nb = 0; disc = 0; pend = 0; hit_done = 0;
`ifdef IF_ICACHE_EN
    for (int k = 0; k < 16; k++) cvalid[k] = 0;
`endif
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_pc"},  if_pc,   RST_PC);
    check_eq({tag, "_cu"},  if_cu,   IFCU_BUSY);
    check_eq({tag, "_req"}, mem_req, 1'b0);
    check_eq({tag, "_is"},  if_is,   32'h0);
  endtask

  // One clock cycle: drive at negedge, check, then advance the model across the posedge.
  task automatic step();
    bit         done, hit_now, exp_req, out_after;
    logic [2:0] exp_cu;
    @(negedge clk);
    rst = s_rst; stall = s_stall; br_taken = s_br; br_target = s_tgt;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    if (!s_rst) begin
      model_reset();
      #1;
      check_reset("rst_hold");
      return;
    end
    #1;
    if (pend && pend_dly == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem[pend_addr[9:0]];
    end
    if (mem_req) mem_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    done    = (nb == 4) || hit_done;
    hit_now = !done && !pend && (nb == 0) && model_hit();
    exp_req = !done && !pend && !hit_now;
    exp_cu  = s_br ? IFCU_FLUSH : (done ? (s_stall ? IFCU_STALL : IFCU_VALID) : IFCU_BUSY);
    check_eq("if_cu", if_cu, exp_cu);
    check_eq("if_pc", if_pc, mpc);
    check_eq("mem_req", mem_req, exp_req);
    if (done) check_eq("if_is", if_is, word_at(mpc));
    if (mem_req) check_eq("mem_addr", mem_addr, mpc + nb);

    out_after = (pend && !mem_rvalid) || (mem_req && mem_gnt);
    if (s_br) begin
      mpc = {s_tgt[31:2], 2'b00}; nb = 0; disc = out_after; hit_done = 0;
    end else begin
      if (mem_rvalid) begin
        if (disc) disc = 0;
        else begin
          nb++;
`ifdef IF_ICACHE_EN
          if (nb == 4) begin cvalid[mpc[5:2]] = 1; cpc[mpc[5:2]] = mpc; end
`endif
        end
      end
      if (hit_now) hit_done = 1;
      if (done && !s_stall) begin mpc = mpc + 32'd4; nb = 0; hit_done = 0; end
    end
    if (mem_rvalid) pend = 0;
    else if (pend)  pend_dly--;
    if (mem_req && mem_gnt) begin
      pend      = 1;
      pend_addr = mem_addr;
      pend_dly  = (rv_dly_cfg < 0) ? int'($urandom_range(0, 2)) : rv_dly_cfg;
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    s_rst = 0; s_stall = 0; s_br = 0; s_tgt = '0; rand_gnt = 0; rv_dly_cfg = 0;
    model_reset();
    repeat (3) step();

    // Reset release, best-case fetch of 0x00000013 at address 0.
    s_rst = 1;
    for (int c = 0; c <= 8; c++) begin
      step();
      if (c == 0) check_eq("first_addr", mem_addr, RST_PC);
    end
    check_eq("lat8_cu", if_cu, IFCU_VALID);
    check_eq("lat8_is", if_is, 32'h00000013);
    check_eq("lat8_pc", if_pc, 32'h0);

    // Asynchronous reset in the middle of WAIT on the fetch at 4.
    step(); step();
    rst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    model_reset();
    check_reset("rst_async");
    s_rst = 0; step(); s_rst = 1;

    // Refetch from RESET_PC, then stall three cycles in DONE.
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 0) check_eq("refetch_addr", mem_addr, RST_PC);
    end
    s_stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall_cu", if_cu, IFCU_STALL);
      check_eq("stall_is", if_is, 32'h00000013);
    end
    s_stall = 0;
    step(); check_eq("stall_rel_cu", if_cu, IFCU_VALID);
    step(); check_eq("next_req", mem_req, 1'b1); check_eq("next_addr", mem_addr, 32'h4);

    // Redirect while WAIT at idx 1 with the byte still outstanding.
    step();
    rv_dly_cfg = 1; step();
    rv_dly_cfg = 0; s_br = 1; s_tgt = 32'h00000102; step();
    check_eq("br_wait_cu", if_cu, IFCU_FLUSH);
    s_br = 0;
    step(); check_eq("drain_nreq", mem_req, 1'b0); check_eq("br_pc", if_pc, 32'h100);
    step(); check_eq("br_req", mem_req, 1'b1); check_eq("br_addr", mem_addr, 32'h100);

    // Redirect and stall together in DONE.
    repeat (7) step();
    s_stall = 1; s_br = 1; s_tgt = 32'h00000200; step();
    check_eq("br_stall_cu", if_cu, IFCU_FLUSH);
    s_stall = 0; s_br = 0; step();
    check_eq("br_stall_pc", if_pc, 32'h200);

`ifdef IF_ICACHE_EN
    // Loop back to 0x40: the second visit must hit without a memory request.
    s_br = 1; s_tgt = 32'h40; step(); s_br = 0;
    repeat (9) step();
    s_br = 1; s_tgt = 32'h40; step(); s_br = 0;
    check_eq("loop_cu", if_cu, IFCU_FLUSH);
    step(); check_eq("hit_nreq", mem_req, 1'b0); check_eq("hit_busy", if_cu, IFCU_BUSY);
    step(); check_eq("hit_cu", if_cu, IFCU_VALID); check_eq("hit_is", if_is, word_at(32'h40));
`endif

    // PC wrap from FFFFFFFC to 0, with an unaligned target.
    s_br = 1; s_tgt = 32'hFFFFFFFE; step(); s_br = 0;
    guard = 0;
    do begin step(); guard++; end while (if_cu != IFCU_VALID && guard < 40);
    check_eq("wrap_valid", if_cu, IFCU_VALID);
    check_eq("wrap_pc", if_pc, 32'hFFFFFFFC);
    step(); check_eq("wrap_addr", mem_addr, 32'h0);

    // Randomized traffic.
    rand_gnt = 1; rv_dly_cfg = -1;
    for (int i = 0; i < 4000; i++) begin
      s_rst   = ($urandom_range(0, 499) != 0);
      s_stall = ($urandom_range(0, 2) == 0);
      s_br    = ($urandom_range(0, 29) == 0);
      s_tgt   = $urandom_range(0, 1) ? 32'($urandom_range(0, 1023))
                                     : 32'h40 + 32'(4 * $urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
